// File: rtl/adaptive_anc_engine.sv
// adaptive_anc_engine: serial LMS adaptive FIR for active noise cancellation.
// Each accepted sample takes TAPS coefficient-update cycles, TAPS MAC cycles and
// one output cycle, so a new sample can be taken every 2*TAPS+2 cycles.
// Build option: define ANC_LEAKAGE_EN for a leaky-LMS coefficient update.
module adaptive_anc_engine #(
  parameter int unsigned TAPS      = 64,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned COEF_FRAC = 10,
  parameter int unsigned MU_SHIFT  = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     ready_in,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] e_in,
  input  logic                     nc_en_in,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     done_out,
  output logic                     busy_out,
  output logic                     overrun_out
);

  localparam int unsigned TAP_W      = $clog2(TAPS);
  localparam int unsigned PROD_W     = 2 * DATA_W;
  localparam int unsigned MAC_W      = DATA_W + COEF_W;
  localparam int unsigned ACC_W      = MAC_W + TAP_W;
  localparam int unsigned WIDE_W     = ACC_W + PROD_W;
  localparam int unsigned LEAK_SHIFT = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_FILTER,
    S_OUT
  } state_t;

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_buf [TAPS];
  logic signed [COEF_W-1:0]  r_w   [TAPS];
  logic [TAP_W-1:0]          r_wr_ptr;
  logic [TAP_W-1:0]          r_k;
  logic signed [DATA_W-1:0]  r_err;
  logic                      r_adapt;
  logic signed [ACC_W-1:0]   r_acc;

  logic [TAP_W-1:0]          w_wr_next;
  logic [TAP_W-1:0]          w_tap_idx;
  logic signed [DATA_W-1:0]  w_x_tap;
  logic signed [COEF_W-1:0]  w_w_cur;
  logic signed [PROD_W-1:0]  w_ex;
  logic signed [COEF_W-1:0]  w_step;
  logic signed [COEF_W-1:0]  w_w_upd;
  logic signed [MAC_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [DATA_W-1:0]  w_y;
  logic                      w_last;

  // Symmetric clamp of a wide signed value into a w-bit signed range (result still wide).
  function automatic logic signed [WIDE_W-1:0] sat_w(input logic signed [WIDE_W-1:0] v,
                                                     input int unsigned w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (WIDE_W'(1) <<< (w - 1)) - WIDE_W'(1);
    lo = ~hi;
    if (v > hi) begin
      sat_w = hi;
    end else if (v < lo) begin
      sat_w = lo;
    end else begin
      sat_w = v;
    end
  endfunction

  // Datapath shared by UPDATE and FILTER: tap k is buf[(wr_ptr - k) mod TAPS].
  always_comb begin
    w_wr_next  = r_wr_ptr + TAP_W'(1);
    w_tap_idx  = r_wr_ptr - r_k;
    w_x_tap    = r_buf[w_tap_idx];
    w_w_cur    = r_w[r_k];
    w_ex       = PROD_W'(r_err) * PROD_W'(w_x_tap);
    w_step     = COEF_W'(sat_w(WIDE_W'(w_ex >>> MU_SHIFT), COEF_W));
`ifdef ANC_LEAKAGE_EN
    w_w_upd    = COEF_W'(sat_w(WIDE_W'(w_w_cur) - WIDE_W'(w_w_cur >>> LEAK_SHIFT)
                               + WIDE_W'(w_step), COEF_W));
`else
    w_w_upd    = COEF_W'(sat_w(WIDE_W'(w_w_cur) + WIDE_W'(w_step), COEF_W));
`endif
    w_prod     = MAC_W'(w_w_cur) * MAC_W'(w_x_tap);
    w_acc_next = r_acc + ACC_W'(w_prod);
    w_y        = DATA_W'(sat_w(WIDE_W'(w_acc_next >>> COEF_FRAC), DATA_W));
    w_last     = (r_k == TAP_W'(TAPS - 1));
  end

  // Control FSM with sample buffer, coefficients, accumulator and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_k         <= '0;
      r_err       <= '0;
      r_adapt     <= 1'b0;
      r_acc       <= '0;
      y_out       <= '0;
      done_out    <= 1'b0;
      busy_out    <= 1'b0;
      overrun_out <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        r_buf[i] <= '0;
        r_w[i]   <= '0;
      end
    end else begin
      done_out    <= 1'b0;
      overrun_out <= ready_in && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (ready_in) begin
            r_buf[w_wr_next] <= x_in;
            r_wr_ptr         <= w_wr_next;
            r_err            <= e_in;
            r_adapt          <= nc_en_in;
            r_k              <= '0;
            busy_out         <= 1'b1;
            r_state          <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (r_adapt) begin
            r_w[r_k] <= w_w_upd;
          end
          r_k <= r_k + TAP_W'(1);
          if (w_last) begin
            r_acc   <= '0;
            r_state <= S_FILTER;
          end
        end
        S_FILTER: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + TAP_W'(1);
          // Final MAC folds straight into y_out so it is visible during OUT.
          if (w_last) begin
            y_out    <= r_adapt ? w_y : '0;
            done_out <= 1'b1;
            r_state  <= S_OUT;
          end
        end
        S_OUT: begin
          busy_out <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adaptive_anc_engine.md
ADAPTIVE_ANC_ENGINE -- requirements
Module: adaptive_anc_engine

Interface
REQ-001 SHALL have parameter TAPS, 64, filter length; power of two, 4..256.
REQ-002 SHALL have parameter DATA_W, 16, sample, error and output width, signed.
REQ-003 SHALL have parameter COEF_W, 16, coefficient width, signed.
REQ-004 SHALL have parameter COEF_FRAC, 10, coefficient fractional bits; output scaling shift.
REQ-005 SHALL have parameter MU_SHIFT, 16, step size as a right shift; mu = 2^-MU_SHIFT.
REQ-006 SHALL have port clk_in  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port ready_in  input  1  one-cycle strobe: new sample and error valid.
REQ-009 SHALL have port x_in  input  DATA_W  reference-mic sample, signed.
REQ-010 SHALL have port e_in  input  DATA_W  error-mic residual, signed.
REQ-011 SHALL have port nc_en_in  input  1  adaptation and output enable.
REQ-012 SHALL have port y_out  output  DATA_W  anti-noise sample, signed, held between updates.
REQ-013 SHALL have port done_out  output  1  one-cycle pulse when y_out updates.
REQ-014 SHALL have port busy_out  output  1  high in every state except IDLE.
REQ-015 SHALL have port overrun_out  output  1  one-cycle pulse when ready_in arrives while busy.

Function
REQ-016 SHALL keep a TAPS-entry ring buffer; tap k = buf[(wr_ptr - k) mod TAPS]; wr_ptr wraps TAPS-1 -> 0.
REQ-017 SHALL, on ready_in in IDLE (cycle 0), write x_in at wr_ptr+1, advance wr_ptr, latch e_in, enter UPDATE.
REQ-018 SHALL in UPDATE (cycles 1..TAPS) update one coefficient per cycle, k=0..TAPS-1: w[k] += sat_COEF_W((e*x[k]) >>> MU_SHIFT), arithmetic shift, sum saturated to COEF_W.
REQ-019 SHALL in FILTER (cycles TAPS+1..2*TAPS) do one MAC per cycle using updated weights into an accumulator of 2*DATA_W+log2(TAPS) bits, no intermediate overflow.
REQ-020 SHALL in OUT (cycle 2*TAPS+1) load y_out = sat_DATA_W(acc >>> COEF_FRAC), pulse done_out, return to IDLE.
REQ-021 SHALL give fixed latency: done_out exactly 2*TAPS+1 cycles after the accepted ready_in.
REQ-022 SHALL ignore ready_in when busy: no buffer write, no error latch; pulse overrun_out the next cycle.
REQ-023 SHALL accept ready_in in the cycle after OUT (back-to-back rate one sample per 2*TAPS+2 cycles).
REQ-024 SHALL, when nc_en_in is low at the accepted ready_in, leave all weights unchanged, load y_out = 0, same timing; nc_en_in sampled only at accept.
REQ-025 SHALL saturate symmetrically to [-(2^(W-1)), 2^(W-1)-1]; no wrap-around.

Reset
REQ-026 SHALL, while rst_in low at a clock edge, clear y_out, done_out, overrun_out, busy_out, wr_ptr, all weights and buffer entries, and enter IDLE.
REQ-027 SHALL abort any in-progress UPDATE/FILTER on reset with no done_out pulse.

Configuration
REQ-028 SHALL, with ANC_LEAKAGE_EN defined, apply leaky LMS in UPDATE: w[k] <= sat(w[k] - (w[k] >>> 12) + step), leak only when nc_en_in was high.
REQ-029 SHALL, without ANC_LEAKAGE_EN, use plain LMS per REQ-018, bit-exact.

Verification (TAPS=4, COEF_FRAC=8, MU_SHIFT=16, leakage off unless stated)
REQ-030 SHALL cover: reset, then x=1000, e=0, nc_en=1 -> done_out at cycle 9, y_out=0, weights remain 0.
REQ-031 SHALL cover: from reset x=4096, e=16384 -> w0=1024, done at cycle 9, y_out=16384.
REQ-032 SHALL cover: ready_in repeated at cycle 3 -> overrun_out at cycle 4, buffer and weights unaffected, done_out still at cycle 9.
REQ-033 SHALL cover: x=32767, e=32767 repeated until weights saturate -> weights clamp at 32767, y_out=32767, no sign flip.
REQ-034 SHALL cover: rst_in low at cycle 5 -> no done_out, y_out=0, next sample behaves as REQ-030.
REQ-035 SHALL cover: ANC_LEAKAGE_EN, w0=4096, e=0 -> w0=4095 after one sample; nc_en=0 -> w0 unchanged, y_out=0.
